// File: rtl/ram_bus_master.sv
// Buffers read/write commands and plays them one at a time onto a cs/rw RAM slave; cs rises one edge after push.
// cmd_ready drops when the FIFO is full; a held response blocks the next launch until it is accepted.
module ram_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        cs,
  output logic        rw,
  output logic [15:0] addr,
  output logic [31:0] data_in,
  input  logic        ready,
  input  logic [31:0] data_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  cmd_t        mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, pop, start;
  cmd_t        head;

  state_t      state_q, state_d;
  logic        cs_q, cs_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] data_in_q, data_in_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign start     = !empty && (!rsp_valid_q || rsp_ready);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_in_q   <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      state_q     <= state_d;
      cs_q        <= cs_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_in_d   = data_in_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    case (state_q)
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A completion on the last allowed cycle still counts as success.
        if (ready) begin
          cs_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = rw_q ? data_out : 32'h0;
          state_d     = GAP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cs_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
          state_d     = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          pop       = 1'b1;
          cs_d      = 1'b1;
          rw_d      = head.rw;
          addr_d    = head.addr;
          data_in_d = head.wdata;
          cnt_d     = '0;
          state_d   = REQ;
        end
      end
    endcase
  end

  assign cs        = cs_q;
  assign rw        = rw_q;
  assign addr      = addr_q;
  assign data_in   = data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule
